// File: rtl/texture_mapper_hls_pkg.sv
// Shared definitions for the texture mapper HLS FIFO slice.
//   clog2         : pointer width for a given entry count (minimum result 1 for depth 2)
//   DefaultWidth  : default data word width
//   DefaultDepth  : default number of entries
//   fifo_flags_t  : registered status flags {full, empty, overflow, underflow}
package texture_mapper_hls_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/texture_mapper_hls_fifo_ram.sv
// Simple dual-port storage array for texture_mapper_hls_fifo.
//   clk   : clock, rising edge
//   we    : write enable; wdata is stored at waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata loads mem[raddr] on the next edge
//   raddr : read address
//   rdata : registered read data, held while re is low
// Storage is not reset. The FIFO never reads an address that is being written with a live
// word, so no write-first bypass is provided.
module texture_mapper_hls_fifo_ram
  import texture_mapper_hls_pkg::*;
#(
  parameter int unsigned width = DefaultWidth,
  parameter int unsigned depth = DefaultDepth,
  parameter int unsigned addr_w = clog2(depth)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic              re,
  input  logic [addr_w-1:0] raddr,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [depth];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/texture_mapper_hls_fifo.sv
// Synchronous single-clock FIFO between HLS-generated texture mapper stages.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high; clears pointers, count and flags, not storage
//   write_en   : push request, accepted when not full
//   write_data : word to push
//   read_en    : pop request, accepted when not empty
//   read_data  : popped word (1-cycle latency), held until the next accepted pop;
//                init_value until the first pop after reset
//   read_valid : one-cycle pulse when read_data is new
//   full/empty : registered, derived from count
//   count      : current occupancy
//   overflow   : one-cycle pulse, write_en seen while full
//   underflow  : one-cycle pulse, read_en seen while empty
// Optional: define TEXTURE_MAPPER_HLS_FIFO_ALMOST_EN to add almost_full / almost_empty
// outputs (count >= almost_full_thresh / count <= almost_empty_thresh).
module texture_mapper_hls_fifo
  import texture_mapper_hls_pkg::*;
#(
  parameter int unsigned     width               = DefaultWidth,
  parameter int unsigned     depth               = DefaultDepth,
  parameter logic [width-1:0] init_value         = '0,
  parameter int unsigned     almost_full_thresh  = 14,
  parameter int unsigned     almost_empty_thresh = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_en,
  input  logic [width-1:0]       write_data,
  input  logic                   read_en,
  output logic [width-1:0]       read_data,
  output logic                   read_valid,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(depth):0]  count,
`ifdef TEXTURE_MAPPER_HLS_FIFO_ALMOST_EN
  output logic                   almost_full,
  output logic                   almost_empty,
`endif
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned PtrW = clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_depth_check
    $error("texture_mapper_hls_fifo: depth must be a power of two >= 2");
  end
  if (almost_empty_thresh > depth || almost_full_thresh > depth) begin : g_thresh_check
    $error("texture_mapper_hls_fifo: almost thresholds exceed depth");
  end

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fifo_flags_t     flags_q, flags_d;
  logic            read_valid_q, read_valid_d;
  // Set by the first accepted pop; until then read_data shows init_value.
  logic            have_data_q, have_data_d;
  logic            wa, ra;
  logic [width-1:0] ram_rdata;

  // Accepts use the registered flags of this cycle; no look-ahead.
  assign wa = write_en & ~flags_q.full;
  assign ra = read_en & ~flags_q.empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    have_data_d  = have_data_q | ra;
    read_valid_d = ra;

    if (wa) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (ra) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (wa && !ra) begin
      count_d = count_q + CntW'(1);
    end else if (ra && !wa) begin
      count_d = count_q - CntW'(1);
    end

    flags_d.full      = (count_d == CntW'(depth));
    flags_d.empty     = (count_d == '0);
    flags_d.overflow  = write_en & flags_q.full;
    flags_d.underflow = read_en & flags_q.empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flags_q      <= '{full: 1'b0, empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
      read_valid_q <= 1'b0;
      have_data_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      flags_q      <= flags_d;
      read_valid_q <= read_valid_d;
      have_data_q  <= have_data_d;
    end
  end

  // Storage writes and reads are gated by reset so the reset cycle is fully ignored.
  texture_mapper_hls_fifo_ram #(
    .width  (width),
    .depth  (depth),
    .addr_w (PtrW)
  ) u_ram (
    .clk   (clk),
    .we    (wa & ~reset),
    .waddr (wr_ptr_q),
    .wdata (write_data),
    .re    (ra & ~reset),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign read_data  = have_data_q ? ram_rdata : init_value;
  assign read_valid = read_valid_q;
  assign full       = flags_q.full;
  assign empty      = flags_q.empty;
  assign overflow   = flags_q.overflow;
  assign underflow  = flags_q.underflow;
  assign count      = count_q;

`ifdef TEXTURE_MAPPER_HLS_FIFO_ALMOST_EN
  logic almost_full_q, almost_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (32'(count_d) >= almost_full_thresh);
      almost_empty_q <= (32'(count_d) <= almost_empty_thresh);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
